// File: rtl/cloud_spawn_scheduler_if.sv
// Control inputs and cloud-state outputs of the cloud spawn scheduler.
// The master side is the scheduler; the slave side is the renderer/controller.
interface cloud_spawn_scheduler_if #(
    parameter int NUM_CLOUDS = 4
);
    logic                    enable;
    logic                    pause;
    logic [NUM_CLOUDS*10-1:0] cloud_x;
    logic [NUM_CLOUDS*10-1:0] cloud_y;
    logic [NUM_CLOUDS-1:0]   cloud_valid;
    logic [9:0]              cloud_size;
    logic [1:0]              state;
    logic [7:0]              drop_count;

    modport master (
        input  enable, pause,
        output cloud_x, cloud_y, cloud_valid, cloud_size, state, drop_count
    );

    modport slave (
        output enable, pause,
        input  cloud_x, cloud_y, cloud_valid, cloud_size, state, drop_count
    );
endinterface

// File: rtl/cloud_spawn_scheduler.sv
// Frame-rate cloud slot scheduler: periodic spawns at a pseudo-random height,
// leftward drift, retirement at the left edge and a saturating drop counter.
module cloud_spawn_scheduler #(
    parameter int          NUM_CLOUDS   = 4,
    parameter int          SPAWN_PERIOD = 120,
    parameter int          X_STEP       = 1,
    parameter int          X_SPAWN      = 639,
    parameter int          Y_MIN        = 250,
    parameter int          CLOUD_SIZE   = 50,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    cloud_spawn_scheduler_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_e;

    localparam int          CNT_W      = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [9:0]  STEP       = 10'(X_STEP);
    localparam logic [9:0]  SPAWN_X    = 10'(X_SPAWN);
    localparam logic [9:0]  BASE_Y     = 10'(Y_MIN);
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    state_e                         state_q, state_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [CNT_W-1:0]               spawn_cnt_q, spawn_cnt_d;
    logic [7:0]                     drop_q, drop_d;
    logic [NUM_CLOUDS-1:0]          valid_q, valid_d;
    logic [NUM_CLOUDS-1:0][9:0]     x_q, x_d;
    logic [NUM_CLOUDS-1:0][9:0]     y_q, y_d;
    logic                           spawn_now;
    logic                           slot_found;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        spawn_cnt_d = spawn_cnt_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        x_d         = x_q;
        y_d         = y_q;
        spawn_now   = 1'b0;
        slot_found  = 1'b0;

        // Galois shift-right LFSR; a nonzero seed can never reach zero.
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = bus.pause ? PAUSE : RUN;
                PAUSE:   state_d = bus.pause ? PAUSE : RUN;
                default: state_d = IDLE;
            endcase
        end

        if (!bus.enable || state_q == IDLE) begin
            // enable=0 clears on the same edge it is seen; drop_count is kept.
            valid_d     = '0;
            x_d         = '0;
            y_d         = '0;
            spawn_cnt_d = '0;
        end else if (state_q == RUN) begin
            spawn_now   = (spawn_cnt_q == CNT_LAST);
            spawn_cnt_d = spawn_now ? '0 : spawn_cnt_q + CNT_W'(1);

            for (int i = 0; i < NUM_CLOUDS; i++) begin
                if (valid_q[i]) begin
                    if (x_q[i] >= STEP) x_d[i] = x_q[i] - STEP;
                    else                valid_d[i] = 1'b0;
                end
            end

            // Eligibility uses start-of-frame valid, so retiring slots are excluded.
            if (spawn_now) begin
                for (int i = 0; i < NUM_CLOUDS; i++) begin
                    if (!slot_found && !valid_q[i]) begin
                        slot_found = 1'b1;
                        valid_d[i] = 1'b1;
                        x_d[i]     = SPAWN_X;
                        y_d[i]     = BASE_Y + {3'b000, lfsr_q[6:0]};
                    end
                end
                if (!slot_found && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            spawn_cnt_q <= '0;
            drop_q      <= '0;
            valid_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            spawn_cnt_q <= spawn_cnt_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign bus.cloud_x     = x_q;
    assign bus.cloud_y     = y_q;
    assign bus.cloud_valid = valid_q;
    assign bus.cloud_size  = 10'(CLOUD_SIZE);
    assign bus.state       = state_q;
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_cloud_spawn_scheduler.sv
// Directed bench: dut_a (2 slots, period 4) covers spawn, drop, pause, disable and reset;
// dut_b (1 slot, spawn X 2, period 3) covers retirement coinciding with a spawn attempt.
module tb_cloud_spawn_scheduler;
    logic frame_clk;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   y_bad    = 0;

    cloud_spawn_scheduler_if #(.NUM_CLOUDS(2)) bus_a ();
    cloud_spawn_scheduler_if #(.NUM_CLOUDS(1)) bus_b ();

    cloud_spawn_scheduler #(.NUM_CLOUDS(2), .SPAWN_PERIOD(4)) dut_a (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus_a)
    );

    cloud_spawn_scheduler #(.NUM_CLOUDS(1), .SPAWN_PERIOD(3), .X_SPAWN(2)) dut_b (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus_b)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Expected spawn height when the LFSR has advanced n times past the seed.
    function automatic logic [31:0] y_after(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int k = 0; k < n; k++) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return 32'(250 + int'(l[6:0]));
    endfunction

    task automatic scan_y();
        for (int i = 0; i < 2; i++)
            if (bus_a.cloud_valid[i] &&
                (bus_a.cloud_y[10*i +: 10] < 10'd250 || bus_a.cloud_y[10*i +: 10] > 10'd377))
                y_bad++;
    endtask

    initial begin
        Reset        = 1'b1;
        bus_a.enable = 1'b0;
        bus_a.pause  = 1'b0;
        bus_b.enable = 1'b0;
        bus_b.pause  = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(bus_a.state), 0);
        check("rst_valid", 32'(bus_a.cloud_valid), 0);
        check("rst_x", 32'(bus_a.cloud_x), 0);
        check("rst_y", 32'(bus_a.cloud_y), 0);
        check("rst_drop", 32'(bus_a.drop_count), 0);
        check("size", 32'(bus_a.cloud_size), 50);

        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;
        Reset        = 1'b0;

        tick(); // edge 1
        check("e1_state_a", 32'(bus_a.state), 1);
        check("e1_state_b", 32'(bus_b.state), 1);
        check("e1_valid_a", 32'(bus_a.cloud_valid), 0);
        repeat (3) tick(); // edge 4
        check("e4_valid_a", 32'(bus_a.cloud_valid), 0);
        check("e4_b_valid", 32'(bus_b.cloud_valid), 1);
        check("e4_b_x", 32'(bus_b.cloud_x), 2);
        check("e4_b_y", 32'(bus_b.cloud_y), y_after(3));
        tick(); // edge 5
        check("e5_valid_a", 32'(bus_a.cloud_valid), 1);
        check("e5_x0", 32'(bus_a.cloud_x[9:0]), 639);
        check("e5_y0", 32'(bus_a.cloud_y[9:0]), y_after(4));
        check("e5_b_x", 32'(bus_b.cloud_x), 1);
        tick(); // edge 6
        check("e6_x0", 32'(bus_a.cloud_x[9:0]), 638);
        check("e6_b_x", 32'(bus_b.cloud_x), 0);
        tick(); // edge 7: retire and spawn attempt coincide
        check("e7_b_valid", 32'(bus_b.cloud_valid), 0);
        check("e7_b_x", 32'(bus_b.cloud_x), 0);
        check("e7_b_drop", 32'(bus_b.drop_count), 1);
        repeat (2) tick(); // edge 9
        check("e9_valid_a", 32'(bus_a.cloud_valid), 3);
        check("e9_x0", 32'(bus_a.cloud_x[9:0]), 635);
        check("e9_x1", 32'(bus_a.cloud_x[19:10]), 639);
        check("e9_y1", 32'(bus_a.cloud_y[19:10]), y_after(8));
        tick(); // edge 10
        check("e10_b_valid", 32'(bus_b.cloud_valid), 1);
        check("e10_b_x", 32'(bus_b.cloud_x), 2);
        check("e10_b_y", 32'(bus_b.cloud_y), y_after(9));
        repeat (3) tick(); // edge 13
        check("e13_drop", 32'(bus_a.drop_count), 1);
        check("e13_x0", 32'(bus_a.cloud_x[9:0]), 631);
        check("e13_x1", 32'(bus_a.cloud_x[19:10]), 635);

        bus_a.pause = 1'b1;
        tick(); // edge 14 still runs, then freezes
        check("p_state", 32'(bus_a.state), 2);
        check("p_x0_enter", 32'(bus_a.cloud_x[9:0]), 630);
        repeat (9) tick(); // edge 23
        check("p_x0_hold", 32'(bus_a.cloud_x[9:0]), 630);
        check("p_x1_hold", 32'(bus_a.cloud_x[19:10]), 634);
        check("p_valid_hold", 32'(bus_a.cloud_valid), 3);
        bus_a.pause = 1'b0;
        tick(); // edge 24
        check("p_resume_state", 32'(bus_a.state), 1);
        check("p_resume_x0", 32'(bus_a.cloud_x[9:0]), 630);
        repeat (2) tick(); // edge 26
        check("p_drop_before", 32'(bus_a.drop_count), 1);
        tick(); // edge 27: attempt shifted by 10 frames
        check("p_drop_after", 32'(bus_a.drop_count), 2);
        check("p_x0_27", 32'(bus_a.cloud_x[9:0]), 627);

        for (int k = 0; k < 400; k++) begin
            tick();
            scan_y();
        end // edge 427
        check("drop_427", 32'(bus_a.drop_count), 102);
        check("x0_427", 32'(bus_a.cloud_x[9:0]), 227);
        check("x1_427", 32'(bus_a.cloud_x[19:10]), 231);
        for (int k = 0; k < 1100; k++) begin
            tick();
            scan_y();
        end
        check("drop_sat", 32'(bus_a.drop_count), 255);
        check("y_range", 32'(y_bad), 0);

        bus_a.enable = 1'b0;
        tick();
        check("dis_state", 32'(bus_a.state), 0);
        check("dis_valid", 32'(bus_a.cloud_valid), 0);
        check("dis_x", 32'(bus_a.cloud_x), 0);
        check("dis_drop", 32'(bus_a.drop_count), 255);
        bus_a.enable = 1'b1;
        repeat (5) tick();
        check("reen_valid", 32'(bus_a.cloud_valid), 1);
        check("reen_x0", 32'(bus_a.cloud_x[9:0]), 639);

        #3 Reset = 1'b1;
        #1;
        check("async_state", 32'(bus_a.state), 0);
        check("async_valid", 32'(bus_a.cloud_valid), 0);
        check("async_x", 32'(bus_a.cloud_x), 0);
        check("async_y", 32'(bus_a.cloud_y), 0);
        check("async_drop", 32'(bus_a.drop_count), 0);
        check("async_b_drop", 32'(bus_b.drop_count), 0);
        #2 Reset = 1'b0;
        tick();
        check("post_rst_state", 32'(bus_a.state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
